// File: rtl/pipe_ts_os_gen.sv
// rtl/pipe_ts_os_gen.sv - PIPE rx-side TS1/TS2 training-set generator with optional SKP insertion
module pipe_ts_os_gen #(
    parameter int DATA_BYTES   = 2,
    parameter int CNT_W        = 10,
    parameter int SKP_INTERVAL = 0
) (
    input  logic                    clk_125mhz,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    ts_type,
    input  logic [CNT_W-1:0]        os_count,
    input  logic [7:0]              link_num,
    input  logic                    link_pad,
    input  logic [7:0]              lane_num,
    input  logic                    lane_pad,
    input  logic [7:0]              n_fts,
    input  logic [7:0]              train_ctrl,
    output logic [8*DATA_BYTES-1:0] rxdata,
    output logic [DATA_BYTES-1:0]   rxdatak,
    output logic                    rxvalid,
    output logic                    rxidle,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        os_sent
);

    generate
        if (DATA_BYTES != 1 && DATA_BYTES != 2 && DATA_BYTES != 4) begin : g_bad_data_bytes
            $error("pipe_ts_os_gen: DATA_BYTES must be 1, 2 or 4");
        end
    endgenerate

    localparam int         TS_BEATS  = 16 / DATA_BYTES;
    localparam int         SKP_BEATS = 4 / DATA_BYTES;
    localparam logic [3:0] TS_LAST   = 4'(TS_BEATS - 1);
    localparam logic [3:0] SKP_LAST  = 4'(SKP_BEATS - 1);
    localparam logic [3:0] DB4       = 4'(DATA_BYTES);
    localparam int         SKP_W     = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL + 1) : 1;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_PAD = 8'hF7;

    typedef enum logic [1:0] {ST_IDLE, ST_TS, ST_SKP} state_t;

    state_t            state;
    logic [3:0]        beat;
    logic [CNT_W-1:0]  cnt_lat;
    logic [SKP_W-1:0]  skp_cnt;
    logic              stop_pend;

    logic              lat_type, lat_link_pad, lat_lane_pad;
    logic [7:0]        lat_link, lat_lane, lat_nfts, lat_tc;

    logic              cur_type, cur_link_pad, cur_lane_pad;
    logic [7:0]        cur_link, cur_lane, cur_nfts, cur_tc;

    logic [15:0][7:0]  ts_sym;
    logic [15:0]       ts_ksym;
    logic [8*DATA_BYTES-1:0] beat_data;
    logic [DATA_BYTES-1:0]   beat_k;
    logic [3:0]        sym_idx;

    logic [CNT_W-1:0]  sent_inc;
    logic [SKP_W-1:0]  skp_cnt_inc;
    logic              burst_end, skp_hit, stop_now;

    // Fields come live on the first beat of a set and from the latch afterwards,
    // so a set is always built from one consistent snapshot.
    always_comb begin
        cur_type     = lat_type;
        cur_link_pad = lat_link_pad;
        cur_lane_pad = lat_lane_pad;
        cur_link     = lat_link;
        cur_lane     = lat_lane;
        cur_nfts     = lat_nfts;
        cur_tc       = lat_tc;
        if (beat == 4'd0) begin
            cur_type     = ts_type;
            cur_link_pad = link_pad;
            cur_lane_pad = lane_pad;
            cur_link     = link_num;
            cur_lane     = lane_num;
            cur_nfts     = n_fts;
            cur_tc       = train_ctrl;
        end
    end

    always_comb begin
        ts_sym     = '0;
        ts_ksym    = '0;
        ts_sym[0]  = SYM_COM;
        ts_ksym[0] = 1'b1;
        ts_sym[1]  = cur_link_pad ? SYM_PAD : cur_link;
        ts_ksym[1] = cur_link_pad;
        ts_sym[2]  = cur_lane_pad ? SYM_PAD : cur_lane;
        ts_ksym[2] = cur_lane_pad;
        ts_sym[3]  = cur_nfts;
        ts_sym[4]  = 8'h02;
        ts_sym[5]  = cur_tc;
        for (int s = 6; s < 16; s++) begin
            ts_sym[s] = cur_type ? 8'h45 : 8'h4A;
        end
    end

    always_comb begin
        beat_data = '0;
        beat_k    = '0;
        sym_idx   = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            sym_idx = beat * DB4 + 4'(i);
            if (state == ST_SKP) begin
                beat_data[8*i +: 8] = (sym_idx == 4'd0) ? SYM_COM : SYM_SKP;
                beat_k[i]           = 1'b1;
            end else begin
                beat_data[8*i +: 8] = ts_sym[sym_idx];
                beat_k[i]           = ts_ksym[sym_idx];
            end
        end
    end

    assign sent_inc    = (&os_sent) ? os_sent : os_sent + 1'b1;
    assign skp_cnt_inc = skp_cnt + 1'b1;
    assign burst_end   = (cnt_lat != '0) && (sent_inc == cnt_lat);
    assign skp_hit     = (SKP_INTERVAL != 0) && (skp_cnt_inc == SKP_W'(SKP_INTERVAL));
    assign stop_now    = stop_pend | stop;

    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            beat         <= '0;
            cnt_lat      <= '0;
            skp_cnt      <= '0;
            stop_pend    <= 1'b0;
            lat_type     <= 1'b0;
            lat_link_pad <= 1'b0;
            lat_lane_pad <= 1'b0;
            lat_link     <= '0;
            lat_lane     <= '0;
            lat_nfts     <= '0;
            lat_tc       <= '0;
            rxdata       <= '0;
            rxdatak      <= '0;
            rxvalid      <= 1'b0;
            rxidle       <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            os_sent      <= '0;
        end else begin
            // busy/done trail the state by one beat, matching the registered data.
            busy <= (state != ST_IDLE);
            done <= (state == ST_IDLE) && busy;
            case (state)
                ST_IDLE: begin
                    rxdata    <= '0;
                    rxdatak   <= '0;
                    rxvalid   <= 1'b0;
                    rxidle    <= 1'b1;
                    beat      <= '0;
                    stop_pend <= 1'b0;
                    if (start && !busy) begin
                        state     <= ST_TS;
                        cnt_lat   <= os_count;
                        os_sent   <= '0;
                        skp_cnt   <= '0;
                        stop_pend <= stop;
                    end
                end
                ST_TS: begin
                    rxdata    <= beat_data;
                    rxdatak   <= beat_k;
                    rxvalid   <= 1'b1;
                    rxidle    <= 1'b0;
                    stop_pend <= stop_now;
                    if (beat == 4'd0) begin
                        lat_type     <= cur_type;
                        lat_link_pad <= cur_link_pad;
                        lat_lane_pad <= cur_lane_pad;
                        lat_link     <= cur_link;
                        lat_lane     <= cur_lane;
                        lat_nfts     <= cur_nfts;
                        lat_tc       <= cur_tc;
                    end
                    if (beat == TS_LAST) begin
                        beat    <= '0;
                        os_sent <= sent_inc;
                        if (burst_end || stop_now) begin
                            state <= ST_IDLE;
                        end else if (skp_hit) begin
                            state   <= ST_SKP;
                            skp_cnt <= '0;
                        end else if (SKP_INTERVAL != 0) begin
                            skp_cnt <= skp_cnt_inc;
                        end
                    end else begin
                        beat <= beat + 4'd1;
                    end
                end
                ST_SKP: begin
                    rxdata    <= beat_data;
                    rxdatak   <= beat_k;
                    rxvalid   <= 1'b1;
                    rxidle    <= 1'b0;
                    stop_pend <= stop_now;
                    if (beat == SKP_LAST) begin
                        beat  <= '0;
                        state <= stop_now ? ST_IDLE : ST_TS;
                    end else begin
                        beat <= beat + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ts_os_gen.sv
// tb/tb_pipe_ts_os_gen.sv - randomized scoreboard bench for pipe_ts_os_gen (2-byte and 4-byte instances)
module tb_pipe_ts_os_gen;

    logic       clk_125mhz = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, ts_type = 1'b0;
    logic [9:0] os_count = '0;
    logic [7:0] link_num = '0, lane_num = '0, n_fts = '0, train_ctrl = '0;
    logic       link_pad = 1'b0, lane_pad = 1'b0;

    logic [15:0] rxdata_a;
    logic [1:0]  rxdatak_a;
    logic        rxvalid_a, rxidle_a, busy_a, done_a;
    logic [9:0]  os_sent_a;
    logic [31:0] rxdata_b;
    logic [3:0]  rxdatak_b;
    logic        rxvalid_b, rxidle_b, busy_b, done_b;
    logic [3:0]  os_sent_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #4 clk_125mhz = ~clk_125mhz;

    pipe_ts_os_gen #(.DATA_BYTES(2), .CNT_W(10), .SKP_INTERVAL(0)) dut_a (
        .clk_125mhz(clk_125mhz), .reset_n(reset_n), .start(start), .stop(stop),
        .ts_type(ts_type), .os_count(os_count), .link_num(link_num), .link_pad(link_pad),
        .lane_num(lane_num), .lane_pad(lane_pad), .n_fts(n_fts), .train_ctrl(train_ctrl),
        .rxdata(rxdata_a), .rxdatak(rxdatak_a), .rxvalid(rxvalid_a), .rxidle(rxidle_a),
        .busy(busy_a), .done(done_a), .os_sent(os_sent_a)
    );

    pipe_ts_os_gen #(.DATA_BYTES(4), .CNT_W(4), .SKP_INTERVAL(2)) dut_b (
        .clk_125mhz(clk_125mhz), .reset_n(reset_n), .start(start), .stop(stop),
        .ts_type(ts_type), .os_count(os_count[3:0]), .link_num(link_num), .link_pad(link_pad),
        .lane_num(lane_num), .lane_pad(lane_pad), .n_fts(n_fts), .train_ctrl(train_ctrl),
        .rxdata(rxdata_b), .rxdatak(rxdatak_b), .rxvalid(rxvalid_b), .rxidle(rxidle_b),
        .busy(busy_b), .done(done_b), .os_sent(os_sent_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each instance holds the symbols of the set in flight and
    // hands out DATA_BYTES of them per beat; set choice is decided at set end.
    bit          m_active [2];
    int          m_len [2], m_pos [2], m_sets [2], m_cnt [2], m_skpc [2];
    bit          m_next_skp [2], m_cur_skp [2], m_stop [2];
    logic [8:0]  m_buf [2][16];
    logic [31:0] e_data [2];
    logic [3:0]  e_k [2];
    logic        e_valid [2], e_idle [2], e_busy [2], e_done [2];
    logic [31:0] e_sent [2];

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_active[n] = 0; m_len[n] = 0; m_pos[n] = 0; m_sets[n] = 0; m_cnt[n] = 0;
            m_skpc[n] = 0; m_next_skp[n] = 0; m_cur_skp[n] = 0; m_stop[n] = 0;
            e_data[n] = '0; e_k[n] = '0; e_valid[n] = 0; e_idle[n] = 1;
            e_busy[n] = 0; e_done[n] = 0; e_sent[n] = '0;
        end
    endtask

    task automatic model_step(input int n);
        logic prev_busy;
        int   db, skpi, cmax;
        prev_busy = e_busy[n];
        db   = (n == 0) ? 2 : 4;
        skpi = (n == 0) ? 0 : 2;
        cmax = (n == 0) ? 1023 : 15;
        if (!m_active[n]) begin
            e_data[n] = '0; e_k[n] = '0; e_valid[n] = 0; e_idle[n] = 1;
            e_busy[n] = 0; e_done[n] = prev_busy;
            if (start && !prev_busy) begin
                m_active[n] = 1; m_len[n] = 0; m_pos[n] = 0; m_next_skp[n] = 0;
                m_sets[n] = 0; m_skpc[n] = 0; m_stop[n] = stop; e_sent[n] = '0;
                m_cnt[n] = int'(os_count) & cmax;
            end
        end else begin
            if (m_pos[n] == m_len[n]) begin
                m_cur_skp[n] = m_next_skp[n];
                m_pos[n] = 0;
                if (m_cur_skp[n]) begin
                    m_len[n] = 4;
                    m_buf[n][0] = {1'b1, 8'hBC};
                    for (int s = 1; s < 4; s++) m_buf[n][s] = {1'b1, 8'h1C};
                end else begin
                    m_len[n] = 16;
                    m_buf[n][0] = {1'b1, 8'hBC};
                    m_buf[n][1] = link_pad ? {1'b1, 8'hF7} : {1'b0, link_num};
                    m_buf[n][2] = lane_pad ? {1'b1, 8'hF7} : {1'b0, lane_num};
                    m_buf[n][3] = {1'b0, n_fts};
                    m_buf[n][4] = {1'b0, 8'h02};
                    m_buf[n][5] = {1'b0, train_ctrl};
                    for (int s = 6; s < 16; s++) m_buf[n][s] = {1'b0, ts_type ? 8'h45 : 8'h4A};
                end
            end
            m_stop[n] = m_stop[n] | stop;
            e_data[n] = '0; e_k[n] = '0;
            for (int i = 0; i < db; i++) begin
                e_data[n][8*i +: 8] = m_buf[n][m_pos[n] + i][7:0];
                e_k[n][i]           = m_buf[n][m_pos[n] + i][8];
            end
            m_pos[n] += db;
            e_valid[n] = 1; e_idle[n] = 0; e_busy[n] = 1; e_done[n] = 0;
            if (m_pos[n] == m_len[n]) begin
                if (!m_cur_skp[n]) begin
                    if (m_sets[n] < cmax) m_sets[n]++;
                    e_sent[n] = m_sets[n];
                    if ((m_cnt[n] != 0 && m_sets[n] == m_cnt[n]) || m_stop[n]) begin
                        m_active[n] = 0;
                    end else begin
                        m_skpc[n]++;
                        m_next_skp[n] = (skpi != 0) && (m_skpc[n] == skpi);
                        if (m_next_skp[n]) m_skpc[n] = 0;
                    end
                end else begin
                    if (m_stop[n]) m_active[n] = 0;
                    else m_next_skp[n] = 0;
                end
            end
        end
    endtask

    always @(posedge clk_125mhz) begin
        if (reset_n) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk_125mhz) begin
        if (reset_n) begin
            check_eq("a_data", {rxdatak_a, rxdata_a}, {e_k[0][1:0], e_data[0][15:0]});
            check_eq("a_flags", {rxvalid_a, rxidle_a, busy_a, done_a},
                     {e_valid[0], e_idle[0], e_busy[0], e_done[0]});
            check_eq("a_sent", os_sent_a, e_sent[0][9:0]);
            check_eq("b_data", {rxdatak_b, rxdata_b}, {e_k[1], e_data[1]});
            check_eq("b_flags", {rxvalid_b, rxidle_b, busy_b, done_b},
                     {e_valid[1], e_idle[1], e_busy[1], e_done[1]});
            check_eq("b_sent", os_sent_b, e_sent[1][3:0]);
        end
    end

    function automatic bit all_idle();
        return !m_active[0] && !m_active[1] && !e_busy[0] && !e_busy[1] && !e_done[0] && !e_done[1];
    endfunction

    task automatic wait_idle(input int budget);
        int c = 0;
        while (c < budget && !all_idle()) begin
            @(negedge clk_125mhz);
            c++;
        end
        if (!all_idle()) check_eq("idle_timeout", 1, 0);
    endtask

    task automatic set_fields(input logic t, input logic [7:0] lk, input logic lkp,
                              input logic [7:0] ln, input logic lnp, input logic [7:0] nf,
                              input logic [7:0] tc);
        ts_type = t; link_num = lk; link_pad = lkp; lane_num = ln; lane_pad = lnp;
        n_fts = nf; train_ctrl = tc;
    endtask

    task automatic rand_fields();
        set_fields(1'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, 8'($urandom),
                   $urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));
    endtask

    task automatic pulse_start(input logic [9:0] cnt);
        os_count = cnt;
        start = 1'b1;
        @(negedge clk_125mhz);
        start = 1'b0;
    endtask

    initial begin
        int cyc, nb;
        logic [35:0] skp_beat;
        model_reset();
        repeat (3) @(negedge clk_125mhz);
        check_eq("rst_a", {rxdata_a, rxdatak_a, rxvalid_a, rxidle_a, busy_a, done_a, os_sent_a},
                 {16'h0, 2'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0});
        check_eq("rst_b", {rxdata_b, rxdatak_b, rxvalid_b, rxidle_b, busy_b, done_b, os_sent_b},
                 {32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        reset_n = 1'b1;
        @(negedge clk_125mhz);

        // basic TS1 burst of two sets
        set_fields(1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 8'h10, 8'h00);
        pulse_start(10'd2);
        @(negedge clk_125mhz);
        check_eq("plan_beat0", {rxdatak_a, rxdata_a}, {2'b01, 16'h00BC});
        @(negedge clk_125mhz);
        check_eq("plan_beat1", {rxdatak_a, rxdata_a}, {2'b00, 16'h1003});
        @(negedge clk_125mhz);
        check_eq("plan_beat2", {rxdatak_a, rxdata_a}, {2'b00, 16'h0002});
        @(negedge clk_125mhz);
        check_eq("plan_beat3", {rxdatak_a, rxdata_a}, {2'b00, 16'h4A4A});
        repeat (13) @(negedge clk_125mhz);
        check_eq("plan_done17", {done_a, busy_a, os_sent_a}, {1'b1, 1'b0, 10'd2});
        wait_idle(50);

        // PAD symbols and TS2
        set_fields(1'b1, 8'h00, 1'b1, 8'h03, 1'b1, 8'h10, 8'h00);
        pulse_start(10'd1);
        @(negedge clk_125mhz);
        check_eq("pad_beat0", {rxdatak_a, rxdata_a}, {2'b11, 16'hF7BC});
        @(negedge clk_125mhz);
        check_eq("pad_beat1", {rxdatak_a, rxdata_a}, {2'b01, 16'h10F7});
        repeat (2) @(negedge clk_125mhz);
        check_eq("pad_beat3", {rxdatak_a, rxdata_a}, {2'b00, 16'h4545});
        wait_idle(50);

        // 4-byte instance: TS,TS,SKP,TS,TS with no trailing SKP
        set_fields(1'b0, 8'h01, 1'b0, 8'h02, 1'b0, 8'h20, 8'h00);
        pulse_start(10'd4);
        nb = 0; cyc = 0; skp_beat = '0;
        while (!done_b && cyc < 40) begin
            @(negedge clk_125mhz);
            if (rxvalid_b) begin
                if (nb == 8) skp_beat = {rxdatak_b, rxdata_b};
                nb++;
            end
            cyc++;
        end
        check_eq("b_beats", nb, 17);
        check_eq("b_skp_beat", skp_beat, {4'hF, 32'h1C1C1CBC});
        check_eq("b_sent4", os_sent_b, 4'd4);
        wait_idle(60);

        // ts_type change and a stray start mid-set
        set_fields(1'b0, 8'h05, 1'b0, 8'h06, 1'b0, 8'h07, 8'h08);
        pulse_start(10'd2);
        repeat (4) @(negedge clk_125mhz);
        ts_type = 1'b1;
        start = 1'b1;
        @(negedge clk_125mhz);
        start = 1'b0;
        repeat (3) @(negedge clk_125mhz);
        check_eq("tog_old_id", rxdata_a, 16'h4A4A);
        repeat (8) @(negedge clk_125mhz);
        check_eq("tog_new_id", rxdata_a, 16'h4545);
        @(negedge clk_125mhz);
        check_eq("tog_done", {done_a, os_sent_a}, {1'b1, 10'd2});
        wait_idle(50);

        // unbounded run, stop during the fifth set
        set_fields(1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 8'h33, 8'h44);
        pulse_start(10'd0);
        repeat (36) @(negedge clk_125mhz);
        stop = 1'b1;
        @(negedge clk_125mhz);
        stop = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 20) begin
            @(negedge clk_125mhz);
            cyc++;
        end
        check_eq("stop_done", done_a, 1'b1);
        check_eq("stop_sent", os_sent_a, 10'd5);
        check_eq("stop_idle", {rxidle_a, rxvalid_a}, 2'b10);
        wait_idle(50);

        // os_sent saturation on the narrow counter
        pulse_start(10'd0);
        repeat (100) @(negedge clk_125mhz);
        stop = 1'b1;
        @(negedge clk_125mhz);
        stop = 1'b0;
        wait_idle(50);
        check_eq("b_sat", os_sent_b, 4'hF);

        // asynchronous reset in the middle of a set
        set_fields(1'b0, 8'h21, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        pulse_start(10'd0);
        repeat (5) @(negedge clk_125mhz);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("arst_a", {rxvalid_a, rxidle_a, busy_a}, 3'b010);
        check_eq("arst_b", {rxvalid_b, rxidle_b, busy_b}, 3'b010);
        @(negedge clk_125mhz);
        reset_n = 1'b1;
        @(negedge clk_125mhz);
        pulse_start(10'd1);
        @(negedge clk_125mhz);
        check_eq("arst_restart", {rxdatak_a, rxdata_a}, {2'b01, 16'h21BC});
        wait_idle(50);

        // randomized bursts against the model
        for (int it = 0; it < 40; it++) begin
            rand_fields();
            os_count = 10'($urandom_range(0, 5));
            start = 1'b1;
            stop = ($urandom_range(0, 9) == 0);
            @(negedge clk_125mhz);
            start = 1'b0;
            stop = 1'b0;
            cyc = 0;
            while (cyc < 600 && !all_idle()) begin
                if ($urandom_range(0, 3) == 0) rand_fields();
                start = ($urandom_range(0, 15) == 0);
                stop = ($urandom_range(0, 60) == 0) || (cyc > 150);
                @(negedge clk_125mhz);
                cyc++;
            end
            start = 1'b0;
            stop = 1'b0;
            if (!all_idle()) check_eq("rand_timeout", 1, 0);
            @(negedge clk_125mhz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
